vga_rect_fill: RTL and testbench

VGA_RECT_FILL -- requirements
Module: vga_rect_fill

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_rect_fill.sv | 133 +++++++++++++
 tb/tb_vga_rect_fill.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA rectangle-fill engine: default frame
// geometry, coordinate width and the fill FSM state type.
package vga_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int COORD_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

endpackage : vga_pkg

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: writes a solid rectangle into a linear framebuffer over an
// Avalon-MM master port, one pixel word per beat, row-major order.
// Optional build macro VGA_RECT_FILL_CLIP_EN clamps the far corner to the
// visible frame and treats a start point outside the frame as empty.
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter int AVN_AW = 18,
    parameter int AVN_DW = 16,
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [COORD_W-1:0]    cmd_x0,
    input  logic [COORD_W-1:0]    cmd_x1,
    input  logic [COORD_W-1:0]    cmd_y0,
    input  logic [COORD_W-1:0]    cmd_y1,
    input  logic [AVN_DW-1:0]     cmd_color,
    output logic                  busy,
    output logic                  done,
    output logic                  framebuffer_avn_write,
    output logic                  framebuffer_avn_read,
    output logic [AVN_AW-1:0]     framebuffer_avn_address,
    output logic [AVN_DW-1:0]     framebuffer_avn_writedata,
    output logic [AVN_DW/8-1:0]   framebuffer_avn_byteenable,
    input  logic                  framebuffer_avn_waitrequest
);

    localparam logic [AVN_AW-1:0] H_RES_AW = AVN_AW'(H_RES);

    fill_state_t            state, state_nxt;
    logic [COORD_W-1:0]     x_cur, y_cur;
    logic [COORD_W-1:0]     x_lo, x_hi, y_hi;
    logic [AVN_AW-1:0]      row_step;
    logic [COORD_W-1:0]     x1_eff, y1_eff;
    logic                   rect_empty;
    logic [AVN_AW-1:0]      start_addr;
    logic                   cmd_accept;
    logic                   wr_accept;
    logic                   row_end;
    logic                   last_pix;

    // Saturate a coordinate to an inclusive upper limit.
    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic [COORD_W-1:0] v,
        input int                 lim
    );
        return (int'(v) > lim) ? COORD_W'(lim) : v;
    endfunction

    // Effective bounds and emptiness of the incoming command.
    always_comb begin
`ifdef VGA_RECT_FILL_CLIP_EN
        x1_eff     = clamp_coord(cmd_x1, H_RES - 1);
        y1_eff     = clamp_coord(cmd_y1, V_RES - 1);
        rect_empty = (int'(cmd_x0) >= H_RES) || (int'(cmd_y0) >= V_RES) ||
                     (cmd_x0 > x1_eff) || (cmd_y0 > y1_eff);
`else
        x1_eff     = cmd_x1;
        y1_eff     = cmd_y1;
        rect_empty = (cmd_x0 > x1_eff) || (cmd_y0 > y1_eff);
`endif
    end

    // The only multiply: first pixel address, taken once at acceptance.
    assign start_addr = AVN_AW'(cmd_y0) * H_RES_AW + AVN_AW'(cmd_x0);

    assign cmd_accept = (state == ST_IDLE) && cmd_valid;
    assign wr_accept  = (state == ST_FILL) && !framebuffer_avn_waitrequest;
    assign row_end    = (x_cur == x_hi);
    assign last_pix   = row_end && (y_cur == y_hi);

    assign cmd_ready                  = (state == ST_IDLE);
    assign busy                       = (state != ST_IDLE);
    assign done                       = (state == ST_DONE);
    assign framebuffer_avn_write      = (state == ST_FILL);
    assign framebuffer_avn_read       = 1'b0;
    assign framebuffer_avn_byteenable = '1;

    // FSM state register; reset aborts any fill in progress at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_accept) state_nxt = rect_empty ? ST_DONE : ST_FILL;
            ST_FILL: if (wr_accept && last_pix) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Cursor and captured bounds; meaningful only while filling.
    always_ff @(posedge sys_clk) begin
        if (cmd_accept) begin
            x_cur    <= cmd_x0;
            y_cur    <= cmd_y0;
            x_lo     <= cmd_x0;
            x_hi     <= x1_eff;
            y_hi     <= y1_eff;
            row_step <= H_RES_AW - AVN_AW'(x1_eff - cmd_x0);
        end else if (wr_accept) begin
            if (row_end) begin
                x_cur <= x_lo;
                y_cur <= y_cur + COORD_W'(1);
            end else begin
                x_cur <= x_cur + COORD_W'(1);
            end
        end
    end

    // Bus address/data; held while the slave stalls, stepped on acceptance.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            framebuffer_avn_address   <= '0;
            framebuffer_avn_writedata <= '0;
        end else if (cmd_accept && !rect_empty) begin
            framebuffer_avn_address   <= start_addr;
            framebuffer_avn_writedata <= cmd_color;
        end else if (wr_accept) begin
            framebuffer_avn_address   <= framebuffer_avn_address +
                                         (row_end ? row_step : AVN_AW'(1));
        end
    end

endmodule : vga_rect_fill

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: directed corner cases plus random
// rectangles, compared against a pixel-list reference model.
module tb_vga_rect_fill;
    import vga_pkg::*;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int HR = 640;
    localparam int VR = 480;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [COORD_W-1:0]   cmd_x0 = '0, cmd_x1 = '0, cmd_y0 = '0, cmd_y1 = '0;
    logic [DW-1:0]        cmd_color = '0;
    logic                 busy, done;
    logic                 framebuffer_avn_write, framebuffer_avn_read;
    logic [AW-1:0]        framebuffer_avn_address;
    logic [DW-1:0]        framebuffer_avn_writedata;
    logic [DW/8-1:0]      framebuffer_avn_byteenable;
    logic                 framebuffer_avn_waitrequest = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    vga_rect_fill #(.AVN_AW(AW), .AVN_DW(DW), .H_RES(HR), .V_RES(VR)) dut (
        .sys_clk                    (sys_clk),
        .sys_rst_n                  (sys_rst_n),
        .cmd_valid                  (cmd_valid),
        .cmd_ready                  (cmd_ready),
        .cmd_x0                     (cmd_x0),
        .cmd_x1                     (cmd_x1),
        .cmd_y0                     (cmd_y0),
        .cmd_y1                     (cmd_y1),
        .cmd_color                  (cmd_color),
        .busy                       (busy),
        .done                       (done),
        .framebuffer_avn_write      (framebuffer_avn_write),
        .framebuffer_avn_read       (framebuffer_avn_read),
        .framebuffer_avn_address    (framebuffer_avn_address),
        .framebuffer_avn_writedata  (framebuffer_avn_writedata),
        .framebuffer_avn_byteenable (framebuffer_avn_byteenable),
        .framebuffer_avn_waitrequest(framebuffer_avn_waitrequest)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: every pixel of the (optionally clipped) rectangle, row-major,
    // linear address y*HR+x reduced modulo the address space.
    function automatic void build_model(input int x0, input int x1, input int y0, input int y1);
        exp_q.delete();
`ifdef VGA_RECT_FILL_CLIP_EN
        if (x1 > HR - 1) x1 = HR - 1;
        if (y1 > VR - 1) y1 = VR - 1;
        if (x0 >= HR || y0 >= VR) return;
`endif
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                exp_q.push_back((y * HR + x) % (1 << AW));
    endfunction

    function automatic logic pick_wait(input int mode, input int accepted, input int stalls);
        case (mode)
            1:       return ($urandom % 3) == 0;
            2:       return (accepted == 1) && (stalls < 3);
            default: return 1'b0;
        endcase
    endfunction

    task automatic scramble_cmd();
        cmd_x0    = COORD_W'($urandom);
        cmd_x1    = COORD_W'($urandom);
        cmd_y0    = COORD_W'($urandom);
        cmd_y1    = COORD_W'($urandom);
        cmd_color = DW'($urandom);
    endtask

    // Issue one command (entered just after a rising edge) and follow it to done.
    task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                           input logic [DW-1:0] color, input int mode);
        int  npix, accepted, stalls, cyc, on_second;
        bit  seen_done;
        accepted = 0; stalls = 0; cyc = 0; on_second = 0; seen_done = 0;
        build_model(x0, x1, y0, y1);
        npix = exp_q.size();
        cmd_x0 = COORD_W'(x0); cmd_x1 = COORD_W'(x1);
        cmd_y0 = COORD_W'(y0); cmd_y1 = COORD_W'(y1);
        cmd_color = color;
        cmd_valid = 1'b1;
        @(negedge sys_clk);
        check("ready_idle", cmd_ready, 1);
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        scramble_cmd();
        framebuffer_avn_waitrequest = pick_wait(mode, accepted, stalls);
        while (cyc < 400) begin
            @(negedge sys_clk);
            cyc++;
            if (framebuffer_avn_write) begin
                if (mode == 2 && accepted == 1) on_second++;
                if (exp_q.size() == 0) begin
                    check("extra_write", 1, 0);
                end else begin
                    check("addr", framebuffer_avn_address, exp_q[0]);
                    check("data", framebuffer_avn_writedata, color);
                end
                if (framebuffer_avn_waitrequest) stalls++;
                else begin
                    accepted++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            check("busy_fill", busy, 1);
            @(posedge sys_clk); #1;
            framebuffer_avn_waitrequest = pick_wait(mode, accepted, stalls);
        end
        check("done_seen", seen_done, 1);
        check("write_count", accepted, npix);
        check("done_cycle", cyc, npix + stalls + 1);
        check("busy_done", busy, 1);
        check("ready_done", cmd_ready, 0);
        if (mode == 2) check("second_hold", on_second, 4);
        @(posedge sys_clk); #1;
        framebuffer_avn_waitrequest = 1'b0;
        @(negedge sys_clk);
        check("ready_after", cmd_ready, 1);
        check("done_after", done, 0);
        check("write_after", framebuffer_avn_write, 0);
        @(posedge sys_clk); #1;
    endtask

    // Start a 100-pixel fill and pull reset while the third write is on the bus.
    task automatic reset_mid_fill();
        int  accepted, cyc;
        bit  hit;
        accepted = 0; cyc = 0; hit = 0;
        build_model(0, 99, 3, 3);
        cmd_x0 = 10'd0; cmd_x1 = 10'd99; cmd_y0 = 10'd3; cmd_y1 = 10'd3;
        cmd_color = 16'h07E0;
        cmd_valid = 1'b1;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        while (cyc < 20) begin
            @(negedge sys_clk);
            cyc++;
            if (framebuffer_avn_write) begin
                check("rst_addr", framebuffer_avn_address, exp_q[0]);
                if (accepted == 2) begin
                    hit = 1;
                    sys_rst_n = 1'b0;
                    #1;
                    check("rst_write", framebuffer_avn_write, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_address", framebuffer_avn_address, 0);
                    check("rst_wdata", framebuffer_avn_writedata, 0);
                    break;
                end
                accepted++;
                void'(exp_q.pop_front());
            end
        end
        check("rst_reached", hit, 1);
        repeat (3) begin
            @(negedge sys_clk);
            check("rst_hold_write", framebuffer_avn_write, 0);
            check("rst_hold_done", done, 0);
        end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            check("post_rst_done", done, 0);
            check("post_rst_write", framebuffer_avn_write, 0);
            check("post_rst_ready", cmd_ready, 1);
        end
        @(posedge sys_clk); #1;
    endtask

    initial begin
        int x0, x1, y0, y1;
        #2;
        check("reset_write", framebuffer_avn_write, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_address", framebuffer_avn_address, 0);
        check("reset_wdata", framebuffer_avn_writedata, 0);
        check("read_tied", framebuffer_avn_read, 0);
        check("byteenable", framebuffer_avn_byteenable, 2'b11);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("ready_release", cmd_ready, 1);
        @(posedge sys_clk); #1;

        run_cmd(0, 0, 0, 0, 16'hF800, 0);
        run_cmd(10, 12, 1, 2, 16'h1234, 0);
        run_cmd(10, 12, 1, 2, 16'hABCD, 2);
        run_cmd(5, 4, 0, 0, 16'h5555, 0);
        run_cmd(0, 0, 7, 6, 16'h5555, 0);
        run_cmd(636, 700, 479, 479, 16'h001F, 0);
        run_cmd(1020, 1023, 1000, 1001, 16'hC0DE, 1);
        reset_mid_fill();
        run_cmd(10, 12, 1, 2, 16'h4321, 0);

        for (int i = 0; i < 24; i++) begin
            x0 = $urandom_range(0, 1023);
            y0 = $urandom_range(0, 1023);
            x1 = x0 + $urandom_range(0, 4);
            y1 = y0 + $urandom_range(0, 3);
            if (x1 > 1023) x1 = 1023;
            if (y1 > 1023) y1 = 1023;
            if ($urandom_range(0, 5) == 0 && x0 > 0) x1 = x0 - 1;
            run_cmd(x0, x1, y0, y1, DW'($urandom), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vga_rect_fill
